// File: rtl/des_cbc_host.sv
// des_cbc_host: host-side initiator for the DES core block handshake.
// It takes one 64-bit block from the upstream stream and applies CBC chaining
// if that mode is selected. It issues the block to the core and waits for the
// core's result strobe, with a timeout. It then returns the result downstream
// with an error code. Only one block is in flight at a time.
//
// state | meaning
// IDLE  | ready for an upstream block
// ISSUE | presenting the block to the core until it accepts
// WAIT  | waiting for the core result, error strobe or timeout
// HOLD  | presenting the result downstream until it is taken

module des_cbc_host #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [63:0] key_in,
    input  logic [63:0] iv_in,
    input  logic        mode_in,
    input  logic        verify_in,
    input  logic        cbc_en_in,
    input  logic [63:0] s_data_in,
    input  logic        s_first_in,
    input  logic        s_valid_in,
    output logic        s_ready_out,
    output logic [63:0] m_data_out,
    output logic [1:0]  m_err_out,
    output logic        m_valid_out,
    input  logic        m_ready_in,
    output logic [63:0] des_data_out,
    output logic [63:0] des_key_out,
    output logic        des_mode_out,
    output logic        des_verify_out,
    output logic        des_valid_out,
    input  logic        des_ready_in,
    input  logic [63:0] des_result_in,
    input  logic        des_result_valid_in,
    input  logic        des_err_in,
    output logic        busy_out
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_KEY     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        state_q;
    logic [63:0]   key_q;
    logic          mode_q;
    logic          verify_q;
    logic          cbc_q;
    logic [63:0]   chain_q;
    logic [63:0]   in_save_q;
    logic [63:0]   core_data_q;
    logic [63:0]   m_data_q;
    logic [1:0]    m_err_q;
    logic          m_valid_q;
    logic          des_valid_q;
    logic          busy_q;
    logic [CW-1:0] cnt_q;

    // A first block must chain and whiten with its own new IV/config, not the stale values
    logic [63:0] chain_sel;
    logic        cbc_sel;
    logic        mode_sel;

    // Select the chaining context that applies to the block being accepted
    always_comb begin
        chain_sel = chain_q;
        cbc_sel   = cbc_q;
        mode_sel  = mode_q;
        if (s_first_in) begin
            chain_sel = iv_in;
            cbc_sel   = cbc_en_in;
            mode_sel  = mode_in;
        end
    end

    // Block sequencing: accept, issue to core, wait for result/timeout, hold for downstream
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            key_q       <= '0;
            mode_q      <= 1'b0;
            verify_q    <= 1'b0;
            cbc_q       <= 1'b0;
            chain_q     <= '0;
            in_save_q   <= '0;
            core_data_q <= '0;
            m_data_q    <= '0;
            m_err_q     <= ERR_OK;
            m_valid_q   <= 1'b0;
            des_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_valid_in) begin
                        if (s_first_in) begin
                            key_q    <= key_in;
                            mode_q   <= mode_in;
                            verify_q <= verify_in;
                            cbc_q    <= cbc_en_in;
                            chain_q  <= iv_in;
                        end
                        core_data_q <= (cbc_sel && !mode_sel) ? (s_data_in ^ chain_sel) : s_data_in;
                        in_save_q   <= s_data_in;
                        des_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (des_ready_in) begin
                        des_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (des_err_in) begin
                        m_data_q  <= '0;
                        m_err_q   <= ERR_KEY;
                        m_valid_q <= 1'b1;
                        state_q   <= HOLD;
                    end else if (des_result_valid_in) begin
                        m_err_q   <= ERR_OK;
                        m_valid_q <= 1'b1;
                        state_q   <= HOLD;
                        if (!mode_q) begin
                            m_data_q <= des_result_in;
                            chain_q  <= des_result_in;
                        end else if (cbc_q) begin
                            m_data_q <= des_result_in ^ chain_q;
                            chain_q  <= in_save_q;
                        end else begin
                            m_data_q <= des_result_in;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        m_data_q  <= '0;
                        m_err_q   <= ERR_TIMEOUT;
                        m_valid_q <= 1'b1;
                        state_q   <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (m_ready_in) begin
                        m_valid_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready is gated by reset so it reads low while reset is held and high in the first IDLE cycle after
    assign s_ready_out    = (state_q == IDLE) && !rst_in;
    assign m_data_out     = m_data_q;
    assign m_err_out      = m_err_q;
    assign m_valid_out    = m_valid_q;
    assign des_data_out   = core_data_q;
    assign des_key_out    = key_q;
    assign des_mode_out   = mode_q;
    assign des_verify_out = verify_q;
    assign des_valid_out  = des_valid_q;
    assign busy_out       = busy_q;

endmodule

// File: tb/tb_des_cbc_host.sv
// Testbench for des_cbc_host. A stand-in core returns the known DES pair for
// the reference key and vector. For any other input it uses a keyed
// invertible scramble. Expected core requests and downstream results come from
// a block-level model of the chaining rules. They are queued for the core
// responder and the output monitor.

module tb_des_cbc_host;

    localparam int TIMEOUT = 8;

    localparam logic [63:0] K0    = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] P0    = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] C0    = 64'h85E8_1354_0F0A_B405;
    localparam logic [63:0] TOY_C = 64'h5A3C_96E1_0F87_D24B;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [63:0] key_in, iv_in;
    logic        mode_in, verify_in, cbc_en_in;
    logic [63:0] s_data_in;
    logic        s_first_in, s_valid_in, s_ready_out;
    logic [63:0] m_data_out;
    logic [1:0]  m_err_out;
    logic        m_valid_out, m_ready_in;
    logic [63:0] des_data_out, des_key_out;
    logic        des_mode_out, des_verify_out, des_valid_out, des_ready_in;
    logic [63:0] des_result_in;
    logic        des_result_valid_in, des_err_in, busy_out;

    always #5 clk_in = ~clk_in;

    des_cbc_host #(.TIMEOUT(TIMEOUT)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .key_in(key_in), .iv_in(iv_in), .mode_in(mode_in), .verify_in(verify_in), .cbc_en_in(cbc_en_in),
        .s_data_in(s_data_in), .s_first_in(s_first_in), .s_valid_in(s_valid_in), .s_ready_out(s_ready_out),
        .m_data_out(m_data_out), .m_err_out(m_err_out), .m_valid_out(m_valid_out), .m_ready_in(m_ready_in),
        .des_data_out(des_data_out), .des_key_out(des_key_out), .des_mode_out(des_mode_out),
        .des_verify_out(des_verify_out), .des_valid_out(des_valid_out), .des_ready_in(des_ready_in),
        .des_result_in(des_result_in), .des_result_valid_in(des_result_valid_in), .des_err_in(des_err_in),
        .busy_out(busy_out)
    );

    typedef struct {
        logic [63:0] data;
        logic [63:0] key;
        logic        mode;
        logic        verify;
        int          beh;      // 0 result, 1 key error, 2 no response
        int          rdy_dly;
        int          lat;
        logic [63:0] res;
    } core_exp_t;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  err;
    } out_exp_t;

    core_exp_t core_q[$];
    out_exp_t  out_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit hold_low = 1'b0;
    int inj_req  = 0;

    logic [63:0] md_key, md_chain;
    logic        md_mode, md_verify, md_cbc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=expired required=event", name);
    endtask

    function automatic logic [63:0] core_enc(input logic [63:0] k, input logic [63:0] x);
        logic [63:0] t;
        if (k == K0 && x == P0) return C0;
        t = x ^ k;
        return {t[50:0], t[63:51]} ^ TOY_C;
    endfunction

    function automatic logic [63:0] core_dec(input logic [63:0] k, input logic [63:0] y);
        logic [63:0] t;
        if (k == K0 && y == C0) return P0;
        t = y ^ TOY_C;
        t = {t[12:0], t[63:13]};
        return t ^ k;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        md_key = '0; md_chain = '0; md_mode = 1'b0; md_verify = 1'b0; md_cbc = 1'b0;
    endtask

    // Model one block at message level, queue expectations, then hand it to the DUT
    task automatic send_block(input logic [63:0] d, input bit first, input logic [63:0] key,
                              input logic [63:0] iv, input bit mode, input bit verify, input bit cbc,
                              input int beh, input int rdy_dly, input int lat);
        core_exp_t   ce;
        out_exp_t    oe;
        logic [63:0] cin, res;
        int          guard;
        if (first) begin
            md_key = key; md_mode = mode; md_verify = verify; md_cbc = cbc; md_chain = iv;
        end
        cin = (md_cbc && !md_mode) ? (d ^ md_chain) : d;
        res = md_mode ? core_dec(md_key, cin) : core_enc(md_key, cin);
        ce.data = cin; ce.key = md_key; ce.mode = md_mode; ce.verify = md_verify;
        ce.beh = beh; ce.rdy_dly = rdy_dly; ce.lat = lat;
        ce.res = (beh == 1) ? rand64() : res;
        if (beh == 0) begin
            oe.err = 2'b00;
            if (!md_mode) begin
                oe.data  = res;
                md_chain = res;
            end else if (md_cbc) begin
                oe.data  = res ^ md_chain;
                md_chain = d;
            end else begin
                oe.data = res;
            end
        end else if (beh == 1) begin
            oe.data = '0; oe.err = 2'b01;
        end else begin
            oe.data = '0; oe.err = 2'b10;
        end
        core_q.push_back(ce);
        out_q.push_back(oe);

        @(posedge clk_in); #1;
        s_data_in = d; s_first_in = first; key_in = key; iv_in = iv;
        mode_in = mode; verify_in = verify; cbc_en_in = cbc; s_valid_in = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk_in);
            if (s_ready_out) break;
            guard++;
            if (guard > 300) begin
                bound_fail("accept_wait");
                break;
            end
        end
        @(posedge clk_in); #1;
        s_valid_in = 1'b0; s_first_in = 1'b0;
        s_data_in = rand64(); key_in = rand64(); iv_in = rand64();
        mode_in = $urandom_range(0, 1); verify_in = $urandom_range(0, 1); cbc_en_in = $urandom_range(0, 1);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        forever begin
            @(negedge clk_in);
            if (out_q.size() == 0 && core_q.size() == 0 && !busy_out) break;
            guard++;
            if (guard > 400) begin
                bound_fail("block_done_wait");
                break;
            end
        end
    endtask

    task automatic wait_core_handshake();
        int guard;
        guard = 0;
        forever begin
            @(negedge clk_in);
            if (des_valid_out && des_ready_in) break;
            guard++;
            if (guard > 100) begin
                bound_fail("core_handshake_wait");
                break;
            end
        end
    endtask

    // Downstream ready: random unless a test forces backpressure
    initial begin
        m_ready_in = 1'b0;
        forever begin
            @(posedge clk_in); #1;
            m_ready_in = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Core responder: checks each request against the model, then answers per the queued behaviour
    initial begin
        int        inj_done;
        core_exp_t ce;
        inj_done = 0;
        des_ready_in = 1'b0; des_result_valid_in = 1'b0; des_err_in = 1'b0; des_result_in = '0;
        forever begin
            @(posedge clk_in); #1;
            if (inj_req != inj_done) begin
                des_result_valid_in = 1'b1; des_err_in = 1'b0; des_result_in = rand64();
                @(posedge clk_in); #1;
                des_result_valid_in = 1'b0;
                inj_done++;
            end else if (des_valid_out && !rst_in) begin
                if (core_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_core_request actual=%h required=none", des_data_out);
                    des_ready_in = 1'b1;
                    @(posedge clk_in); #1;
                    des_ready_in = 1'b0;
                end else begin
                    ce = core_q.pop_front();
                    repeat (ce.rdy_dly) @(posedge clk_in);
                    #1;
                    des_ready_in = 1'b1;
                    @(negedge clk_in);
                    chk("des_valid_held", 64'(des_valid_out), 64'd1);
                    chk("des_data", des_data_out, ce.data);
                    chk("des_key", des_key_out, ce.key);
                    chk("des_mode", 64'(des_mode_out), 64'(ce.mode));
                    chk("des_verify", 64'(des_verify_out), 64'(ce.verify));
                    @(posedge clk_in); #1;
                    des_ready_in = 1'b0;
                    if (ce.beh != 2) begin
                        repeat (ce.lat) @(posedge clk_in);
                        #1;
                        des_result_valid_in = 1'b1;
                        des_err_in = (ce.beh == 1);
                        des_result_in = ce.res;
                        @(posedge clk_in); #1;
                        des_result_valid_in = 1'b0;
                        des_err_in = 1'b0;
                    end
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on each downstream handshake and checks hold stability
    initial begin
        bit          held;
        logic [63:0] ld;
        logic [1:0]  le;
        out_exp_t    oe;
        held = 1'b0; ld = '0; le = '0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                held = 1'b0;
            end else if (m_valid_out) begin
                if (held) begin
                    chk("hold_data_stable", m_data_out, ld);
                    chk("hold_err_stable", 64'(m_err_out), 64'(le));
                end
                if (m_ready_in) begin
                    held = 1'b0;
                    if (out_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output actual=%h/%b required=none", m_data_out, m_err_out);
                    end else begin
                        oe = out_q.pop_front();
                        chk("m_data", m_data_out, oe.data);
                        chk("m_err", 64'(m_err_out), 64'(oe.err));
                    end
                end else begin
                    held = 1'b1; ld = m_data_out; le = m_err_out;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] c2, k, v;
        int          n, r, beh, guard;
        bit          first;
        rst_in = 1'b1;
        s_data_in = '0; s_first_in = 1'b0; s_valid_in = 1'b0;
        key_in = '0; iv_in = '0; mode_in = 1'b0; verify_in = 1'b0; cbc_en_in = 1'b0;
        model_reset();

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("reset_s_ready", 64'(s_ready_out), 64'd0);
        chk("reset_busy", 64'(busy_out), 64'd0);
        chk("reset_m_valid", 64'(m_valid_out), 64'd0);
        chk("reset_des_valid", 64'(des_valid_out), 64'd0);
        chk("reset_m_data", m_data_out, 64'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("idle_s_ready", 64'(s_ready_out), 64'd1);
        chk("idle_busy", 64'(busy_out), 64'd0);

        // ECB encrypt of the reference vector
        send_block(P0, 1, K0, 64'd0, 0, 0, 0, 0, 0, 2);
        wait_done();

        // CBC encrypt, IV 0, two identical blocks
        send_block(P0, 1, K0, 64'd0, 0, 0, 1, 0, 1, 3);
        wait_done();
        send_block(P0, 0, rand64(), rand64(), 1, 1, 0, 0, 0, 1);
        wait_done();
        c2 = core_enc(K0, P0 ^ C0);

        // CBC decrypt of those ciphertexts recovers the plaintext twice
        send_block(C0, 1, K0, 64'd0, 1, 1, 1, 0, 2, 0);
        wait_done();
        send_block(c2, 0, rand64(), rand64(), 0, 0, 0, 0, 0, 4);
        wait_done();

        // Key error leaves the chain untouched for the next block
        k = rand64(); v = rand64();
        send_block(rand64(), 1, k, v, 0, 1, 1, 1, 0, 2);
        wait_done();
        send_block(rand64(), 0, rand64(), rand64(), 1, 0, 0, 0, 1, 1);
        wait_done();

        // Result on the last WAIT cycle beats the timeout
        send_block(rand64(), 0, rand64(), rand64(), 0, 0, 0, 0, 0, TIMEOUT - 1);
        wait_done();

        // Long stall in ISSUE does not time out
        send_block(rand64(), 0, rand64(), rand64(), 0, 0, 0, 0, 3 * TIMEOUT, 0);
        wait_done();

        // Timeout latency, and late strobes in HOLD and IDLE produce nothing
        hold_low = 1'b1;
        send_block(rand64(), 1, rand64(), rand64(), 0, 0, 1, 2, 0, 0);
        wait_core_handshake();
        n = 0;
        forever begin
            @(negedge clk_in);
            n++;
            if (m_valid_out || n > 40) break;
        end
        chk("timeout_latency", 64'(n), 64'(TIMEOUT + 1));
        inj_req++;
        repeat (3) @(negedge clk_in);
        hold_low = 1'b0;
        wait_done();
        inj_req++;
        repeat (4) @(negedge clk_in);
        chk("late_strobe_no_valid", 64'(m_valid_out), 64'd0);
        chk("late_strobe_not_busy", 64'(busy_out), 64'd0);

        // Backpressure: result held, upstream not ready
        hold_low = 1'b1;
        send_block(rand64(), 0, rand64(), rand64(), 0, 0, 0, 0, 1, 2);
        guard = 0;
        while (!m_valid_out && guard < 100) begin
            @(negedge clk_in);
            guard++;
        end
        if (guard >= 100) bound_fail("bp_valid_wait");
        repeat (5) begin
            @(negedge clk_in);
            chk("bp_m_valid", 64'(m_valid_out), 64'd1);
            chk("bp_s_ready", 64'(s_ready_out), 64'd0);
        end
        hold_low = 1'b0;
        wait_done();

        // Reset in WAIT clears everything; later strobes are ignored
        send_block(rand64(), 1, rand64() | 64'd1, rand64(), 1, 1, 1, 2, 0, 0);
        wait_core_handshake();
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rst_m_data", m_data_out, 64'd0);
        chk("rst_m_err", 64'(m_err_out), 64'd0);
        chk("rst_m_valid", 64'(m_valid_out), 64'd0);
        chk("rst_des_data", des_data_out, 64'd0);
        chk("rst_des_key", des_key_out, 64'd0);
        chk("rst_des_mode", 64'(des_mode_out), 64'd0);
        chk("rst_des_verify", 64'(des_verify_out), 64'd0);
        chk("rst_des_valid", 64'(des_valid_out), 64'd0);
        chk("rst_busy", 64'(busy_out), 64'd0);
        chk("rst_s_ready", 64'(s_ready_out), 64'd0);
        out_q.delete();
        core_q.delete();
        model_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        inj_req++;
        repeat (4) @(negedge clk_in);
        chk("post_rst_no_valid", 64'(m_valid_out), 64'd0);
        chk("post_rst_not_busy", 64'(busy_out), 64'd0);
        // Non-first block right after reset runs with cleared config and chain
        send_block(rand64(), 0, rand64(), rand64(), 1, 1, 1, 0, 0, 1);
        wait_done();
        send_block(rand64(), 1, rand64(), rand64(), 0, 1, 1, 0, 1, 2);
        wait_done();

        // Randomized messages
        for (int i = 0; i < 40; i++) begin
            first = (i == 0) || ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            beh = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
            send_block(rand64(), first, rand64(), rand64(), $urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 1), beh, $urandom_range(0, 3), $urandom_range(0, TIMEOUT - 1));
            wait_done();
        end

        repeat (3) @(negedge clk_in);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
